// File: rtl/iso7816_pkg.sv
// Shared ISO7816 receive-path definitions: stored entry layout and the
// capture FSM state encoding.
package iso7816_pkg;

    localparam int RX_ENTRY_W  = 9;
    localparam int RX_FERR_BIT = 8;

    typedef enum logic {
        CAP_WAIT = 1'b0,
        CAP_ACK  = 1'b1
    } cap_state_t;

endpackage

// File: rtl/iso7816_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers and a show-ahead read port.
// A push while full is accepted only when a pop frees the head on the same edge.
module iso7816_sync_fifo #(
    parameter int WIDTH      = 9,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  nReset,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      pop_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr;
    logic [DEPTH_LOG2:0] rd_ptr;
    logic                wr_en;
    logic                rd_en;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                   (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    assign rd_en = pop & ~empty;
    assign wr_en = push & (~full | rd_en);
    assign level = wr_ptr - rd_ptr;

    // At full, the write slot is the head slot; the head is consumed on this same edge.
    assign pop_data = mem[rd_ptr[DEPTH_LOG2-1:0]];

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[DEPTH_LOG2-1:0]] <= push_data;
    end

endmodule

// File: rtl/rx_char_buffer.sv
// Receive character buffer between the ISO7816 RxCore and the host: acks each
// character, queues {frameErr,data}, and keeps error counters plus a sticky overflow flag.
module rx_char_buffer
    import iso7816_pkg::*;
#(
    parameter int DEPTH_LOG2 = 3,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  nReset,
    input  logic [7:0]            rxData,
    input  logic                  rxDataReady,
    input  logic                  rxFrameError,
    input  logic                  rxOverrunError,
    output logic                  rxAck,
    input  logic                  dropErrored,
    output logic [7:0]            outData,
    output logic                  outFrameErr,
    output logic                  outValid,
    input  logic                  outReady,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  fifoOverflow,
    output logic [CNT_WIDTH-1:0]  frameErrCount,
    output logic [CNT_WIDTH-1:0]  overrunCount,
    input  logic                  clearStatus
);

    cap_state_t               state_q, state_d;
    logic                     capture;
    logic                     push_req;
    logic                     pop;
    logic                     full;
    logic                     empty;
    logic                     overflow_evt;
    logic                     ovr_prev;
    logic [RX_ENTRY_W-1:0]    head;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) state_q <= CAP_WAIT;
        else         state_q <= state_d;
    end

    // Flags are ignored in ACK: RxCore drops them on the edge that sees rxAck.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            CAP_WAIT: begin
                if (rxDataReady | rxFrameError) begin
                    capture = 1'b1;
                    state_d = CAP_ACK;
                end
            end
            CAP_ACK:  state_d = CAP_WAIT;
            default:  state_d = CAP_WAIT;
        endcase
    end

    assign rxAck        = (state_q == CAP_ACK);
    assign push_req     = capture & ~(rxFrameError & dropErrored);
    assign pop          = outValid & outReady;
    assign overflow_evt = push_req & full & ~pop;

    iso7816_sync_fifo #(
        .WIDTH      (RX_ENTRY_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk       (clk),
        .nReset    (nReset),
        .push      (push_req),
        .push_data ({rxFrameError, rxData}),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty),
        .level     (level)
    );

    assign outValid    = ~empty;
    assign outData     = head[7:0];
    assign outFrameErr = head[RX_FERR_BIT];

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) ovr_prev <= 1'b0;
        else         ovr_prev <= rxOverrunError;
    end

    // clearStatus has priority; a coincident increment or overflow is discarded.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            frameErrCount <= '0;
            overrunCount  <= '0;
            fifoOverflow  <= 1'b0;
        end else if (clearStatus) begin
            frameErrCount <= '0;
            overrunCount  <= '0;
            fifoOverflow  <= 1'b0;
        end else begin
            if (capture && rxFrameError && (frameErrCount != '1))
                frameErrCount <= frameErrCount + CNT_WIDTH'(1);
            if (rxOverrunError && !ovr_prev && (overrunCount != '1))
                overrunCount <= overrunCount + CNT_WIDTH'(1);
            if (overflow_evt)
                fifoOverflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rx_char_buffer.sv
// Bench for rx_char_buffer: directed scenarios plus randomized traffic, all
// compared every cycle against a queue-based model of the buffer.
module tb_rx_char_buffer;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       nReset;
    logic [7:0] rxData;
    logic       rxDataReady, rxFrameError, rxOverrunError;
    logic       rxAck;
    logic       dropErrored;
    logic [7:0] outData;
    logic       outFrameErr, outValid, outReady;
    logic [3:0] level;
    logic       fifoOverflow;
    logic [7:0] frameErrCount, overrunCount;
    logic       clearStatus;

    int checks = 0;
    int failures = 0;

    rx_char_buffer dut (
        .clk            (clk),
        .nReset         (nReset),
        .rxData         (rxData),
        .rxDataReady    (rxDataReady),
        .rxFrameError   (rxFrameError),
        .rxOverrunError (rxOverrunError),
        .rxAck          (rxAck),
        .dropErrored    (dropErrored),
        .outData        (outData),
        .outFrameErr    (outFrameErr),
        .outValid       (outValid),
        .outReady       (outReady),
        .level          (level),
        .fifoOverflow   (fifoOverflow),
        .frameErrCount  (frameErrCount),
        .overrunCount   (overrunCount),
        .clearStatus    (clearStatus)
    );

    always #5 clk = ~clk;

    // Model: a queue of {ferr,data}, an "ack owed" bit and plain counters.
    logic [8:0] q[$];
    bit         m_ack;
    bit         m_ovf;
    bit         m_ovr_prev;
    logic [7:0] m_fe;
    logic [7:0] m_or;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ack = 0; m_ovf = 0; m_ovr_prev = 0;
        m_fe = 8'd0; m_or = 8'd0;
    endtask

    task automatic model_step();
        bit cap, pop, push, ovf_evt;
        int sz;
        cap  = !m_ack && (rxDataReady || rxFrameError);
        sz   = q.size();
        pop  = (sz > 0) && outReady;
        push = cap && !(rxFrameError && dropErrored);
        ovf_evt = 0;
        if (pop) void'(q.pop_front());
        if (push) begin
            if (sz < DEPTH || pop) q.push_back({rxFrameError, rxData});
            else ovf_evt = 1;
        end
        if (clearStatus) begin
            m_fe = 8'd0; m_or = 8'd0; m_ovf = 0;
        end else begin
            if (cap && rxFrameError && m_fe != 8'hFF) m_fe = m_fe + 8'd1;
            if (rxOverrunError && !m_ovr_prev && m_or != 8'hFF) m_or = m_or + 8'd1;
            if (ovf_evt) m_ovf = 1;
        end
        m_ovr_prev = rxOverrunError;
        m_ack = cap;
    endtask

    // Single compare process against the model, on the falling edge.
    always @(negedge clk) begin
        if (nReset) begin
            chk("rxAck", int'(rxAck), int'(m_ack));
            chk("outValid", int'(outValid), int'(q.size() != 0));
            chk("level", int'(level), q.size());
            chk("fifoOverflow", int'(fifoOverflow), int'(m_ovf));
            chk("frameErrCount", int'(frameErrCount), int'(m_fe));
            chk("overrunCount", int'(overrunCount), int'(m_or));
            if (q.size() > 0) begin
                chk("outData", int'(outData), int'(q[0][7:0]));
                chk("outFrameErr", int'(outFrameErr), int'(q[0][8]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        if (nReset) model_step();
        #2;
    endtask

    task automatic send_char(input logic [7:0] d, input logic f);
        rxData = d; rxDataReady = 1'b1; rxFrameError = f;
        tick();
        rxDataReady = 1'b0; rxFrameError = 1'b0;
        chk("ack_pulse", int'(rxAck), 1);
        tick();
        chk("ack_drop", int'(rxAck), 0);
    endtask

    task automatic clear_status();
        clearStatus = 1'b1;
        tick();
        clearStatus = 1'b0;
    endtask

    task automatic drain_expect(input logic [7:0] d);
        outReady = 1'b1;
        chk("drain_data", int'(outData), int'(d));
        tick();
        outReady = 1'b0;
    endtask

    initial begin
        nReset = 1'b0;
        rxData = 8'h00; rxDataReady = 0; rxFrameError = 0; rxOverrunError = 0;
        dropErrored = 0; outReady = 0; clearStatus = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        chk("rst_ack", int'(rxAck), 0);
        chk("rst_valid", int'(outValid), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_ovf", int'(fifoOverflow), 0);
        chk("rst_fe", int'(frameErrCount), 0);
        chk("rst_or", int'(overrunCount), 0);
        nReset = 1'b1;
        tick();

        // 1: single good character
        send_char(8'h3B, 1'b0);
        chk("t1_data", int'(outData), 'h3B);
        chk("t1_ferr", int'(outFrameErr), 0);
        chk("t1_level", int'(level), 1);
        drain_expect(8'h3B);

        // 2: frame-errored character kept, then dropped
        send_char(8'hA5, 1'b1);
        chk("t2_level", int'(level), 1);
        chk("t2_ferr", int'(outFrameErr), 1);
        chk("t2_fe1", int'(frameErrCount), 1);
        drain_expect(8'hA5);
        dropErrored = 1'b1;
        send_char(8'hA5, 1'b1);
        chk("t2_level0", int'(level), 0);
        chk("t2_fe2", int'(frameErrCount), 2);
        dropErrored = 1'b0;

        // 3: nine characters into an eight-entry FIFO
        for (int i = 0; i < 9; i++) send_char(8'(i), 1'b0);
        chk("t3_level", int'(level), 8);
        chk("t3_ovf", int'(fifoOverflow), 1);
        for (int i = 0; i < 8; i++) drain_expect(8'(i));
        chk("t3_empty", int'(outValid), 0);

        // 4: push and pop on the same edge while full
        clear_status();
        for (int i = 0; i < 8; i++) send_char(8'(8'h10 + i), 1'b0);
        rxData = 8'h55; rxDataReady = 1'b1; outReady = 1'b1;
        tick();
        rxDataReady = 1'b0; outReady = 1'b0;
        chk("t4_level", int'(level), 8);
        chk("t4_ovf", int'(fifoOverflow), 0);
        tick();
        for (int i = 1; i < 8; i++) drain_expect(8'(8'h10 + i));
        drain_expect(8'h55);

        // 5: overrun edge counting, saturation, clear priority
        rxOverrunError = 1'b1;
        repeat (20) tick();
        rxOverrunError = 1'b0;
        tick();
        chk("t5_or", int'(overrunCount), 1);
        dropErrored = 1'b1;
        for (int i = 0; i < 300; i++) send_char(8'($urandom), 1'b1);
        chk("t5_fe_sat", int'(frameErrCount), 255);
        rxFrameError = 1'b1; clearStatus = 1'b1;
        tick();
        rxFrameError = 1'b0; clearStatus = 1'b0;
        chk("t5_clr_win", int'(frameErrCount), 0);
        tick();
        dropErrored = 1'b0;

        // 6: asynchronous reset mid-operation
        send_char(8'h61, 1'b1);
        for (int i = 0; i < 3; i++) send_char(8'(8'h62 + i), 1'b0);
        rxData = 8'h99; rxDataReady = 1'b1;
        tick();
        rxDataReady = 1'b0;
        chk("t6_ack_pre", int'(rxAck), 1);
        chk("t6_level_pre", int'(level), 5);
        nReset = 1'b0;
        model_reset();
        #1;
        chk("t6_ack", int'(rxAck), 0);
        chk("t6_valid", int'(outValid), 0);
        chk("t6_level", int'(level), 0);
        chk("t6_fe", int'(frameErrCount), 0);
        chk("t6_or", int'(overrunCount), 0);
        chk("t6_ovf", int'(fifoOverflow), 0);
        tick();
        nReset = 1'b1;
        tick();
        send_char(8'h77, 1'b0);
        chk("t6_after", int'(outData), 'h77);
        chk("t6_after_lvl", int'(level), 1);

        // Randomized traffic with varying host drain rate
        for (int seg = 0; seg < 4; seg++) begin
            int rdy_pct;
            rdy_pct = (seg == 0) ? 10 : (seg == 1) ? 50 : (seg == 2) ? 90 : 30;
            for (int c = 0; c < 800; c++) begin
                rxData         = 8'($urandom);
                rxDataReady    = ($urandom_range(0, 3) == 0);
                rxFrameError   = ($urandom_range(0, 7) == 0);
                rxOverrunError = ($urandom_range(0, 5) == 0);
                outReady       = ($urandom_range(0, 99) < rdy_pct);
                clearStatus    = ($urandom_range(0, 63) == 0);
                if ($urandom_range(0, 31) == 0) dropErrored = ~dropErrored;
                tick();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
